// File: rtl/cpu15_pkg.sv
// Shared cpu15 definitions: instruction-phase states and opcode constants.
package cpu15_pkg;

   typedef enum logic [2:0] {
      ST_HALTED = 3'd0,
      ST_FT     = 3'd1,
      ST_DC     = 3'd2,
      ST_EX     = 3'd3,
      ST_WB     = 3'd4
   } phase_e;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/cpu15_seq_ctrl_phase_div.sv
// Per-phase cycle divider: counts 0..DIV-1 and flags the terminal cycle of a phase.
module cpu15_phase_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt_r;

   assign tick = (div_cnt_r == LAST);

   // Phase cycle counter; a held terminal cycle keeps the phase open for a stall.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt_r <= {CW{1'b0}};
      end else if (tick && hold) begin
         div_cnt_r <= div_cnt_r;
      end else if (tick) begin
         div_cnt_r <= {CW{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/cpu15_seq_ctrl.sv
// cpu15 instruction-phase sequencer: FT/DC/EX/WB enables with run/halt/step control
// and EX wait-state stalling.
module cpu15_seq_ctrl
   import cpu15_pkg::*;
#(
   parameter int         DIV     = 4,
   parameter logic [3:0] HALT_OP = OP_HLT,
   parameter int         CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             RUN,
   input  logic             STEP,
   input  logic             HALT_REQ,
   input  logic [3:0]       OP_CODE,
   input  logic             WAIT,
   output logic             EN_FT,
   output logic             EN_DC,
   output logic             EN_EX,
   output logic             EN_WB,
   output logic             RUNNING,
   output logic             HALTED,
   output logic [CNT_W-1:0] INSTR_CNT
);

   phase_e           state_r;
   phase_e           state_next_s;
   logic             halt_pend_r;
   logic             step_mode_r;
   logic             run_arm_r;
   logic             halted_r;
   logic             running_r;
   logic [CNT_W-1:0] instr_cnt_r;
   logic             tick_s;
   logic             stall_s;
   logic             clear_s;
   logic             enter_halt_s;
   logic             step_start_s;

   assign clear_s = (state_r == ST_HALTED);
   assign stall_s = (state_r == ST_EX) && WAIT;

   cpu15_phase_div #(.DIV(DIV)) u_div (
      .clk   (CLK),
      .reset (RESET),
      .clear (clear_s),
      .hold  (stall_s),
      .tick  (tick_s)
   );

   assign EN_FT = (state_r == ST_FT) && tick_s;
   assign EN_DC = (state_r == ST_DC) && tick_s;
   assign EN_EX = (state_r == ST_EX) && tick_s && !WAIT;
   assign EN_WB = (state_r == ST_WB) && tick_s;

   assign RUNNING   = running_r;
   assign HALTED    = halted_r;
   assign INSTR_CNT = instr_cnt_r;

   // Next phase; STEP outranks RUN when leaving HALTED.
   always_comb begin
      state_next_s = state_r;
      enter_halt_s = 1'b0;
      step_start_s = 1'b0;
      case (state_r)
         ST_HALTED: begin
            if (STEP) begin
               state_next_s = ST_FT;
               step_start_s = 1'b1;
            end else if (RUN && !halt_pend_r && run_arm_r) begin
               state_next_s = ST_FT;
            end else begin
               state_next_s = ST_HALTED;
            end
         end
         ST_FT: state_next_s = tick_s ? ST_DC : ST_FT;
         ST_DC: state_next_s = tick_s ? ST_EX : ST_DC;
         ST_EX: state_next_s = EN_EX ? ST_WB : ST_EX;
         ST_WB: begin
            if (EN_WB) begin
               if (halt_pend_r || HALT_REQ || step_mode_r || !RUN) begin
                  state_next_s = ST_HALTED;
                  enter_halt_s = 1'b1;
               end else begin
                  state_next_s = ST_FT;
               end
            end else begin
               state_next_s = ST_WB;
            end
         end
         default: state_next_s = ST_HALTED;
      endcase
   end

   // Phase state plus halt/step/run-arm bookkeeping.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r     <= ST_HALTED;
         halted_r    <= 1'b1;
         running_r   <= 1'b0;
         halt_pend_r <= 1'b0;
         step_mode_r <= 1'b0;
         run_arm_r   <= 1'b1;
      end else begin
         state_r   <= state_next_s;
         halted_r  <= (state_next_s == ST_HALTED);
         running_r <= (state_next_s != ST_HALTED);
         if (enter_halt_s) begin
            halt_pend_r <= 1'b0;
         end else if (HALT_REQ || (EN_EX && (OP_CODE == HALT_OP))) begin
            halt_pend_r <= 1'b1;
         end else begin
            halt_pend_r <= halt_pend_r;
         end
         if (enter_halt_s) begin
            step_mode_r <= 1'b0;
         end else if (step_start_s) begin
            step_mode_r <= 1'b1;
         end else begin
            step_mode_r <= step_mode_r;
         end
         // RUN held high across a halt must drop before it can restart the core.
         if (!RUN) begin
            run_arm_r <= 1'b1;
         end else if (enter_halt_s) begin
            run_arm_r <= 1'b0;
         end else begin
            run_arm_r <= run_arm_r;
         end
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         instr_cnt_r <= {CNT_W{1'b0}};
      end else if (EN_WB) begin
         instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      end else begin
         instr_cnt_r <= instr_cnt_r;
      end
   end

endmodule

// File: tb/tb_cpu15_seq_ctrl.sv
// Bench for cpu15_seq_ctrl: DIV=1 and DIV=4 instances on shared stimulus, a vector table,
// directed corner sequences and random traffic against a cycle-level reference model.
module tb_cpu15_seq_ctrl;
   import cpu15_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, run = 1'b0, step = 1'b0, hreq = 1'b0, wt = 1'b0;
   logic [3:0] op = 4'h0;
   logic ft1, dc1, ex1, wb1, rn1, hl1, ft4, dc4, ex4, wb4, rn4, hl4;
   logic [15:0] cnt1, cnt4;

   cpu15_seq_ctrl #(.DIV(1), .HALT_OP(OP_HLT), .CNT_W(16)) dut1 (
      .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .HALT_REQ(hreq), .OP_CODE(op), .WAIT(wt),
      .EN_FT(ft1), .EN_DC(dc1), .EN_EX(ex1), .EN_WB(wb1), .RUNNING(rn1), .HALTED(hl1),
      .INSTR_CNT(cnt1));

   cpu15_seq_ctrl #(.DIV(4), .HALT_OP(OP_HLT), .CNT_W(16)) dut4 (
      .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .HALT_REQ(hreq), .OP_CODE(op), .WAIT(wt),
      .EN_FT(ft4), .EN_DC(dc4), .EN_EX(ex4), .EN_WB(wb4), .RUNNING(rn4), .HALTED(hl4),
      .INSTR_CNT(cnt4));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: phase index -1 = halted, 0..3 = FT,DC,EX,WB; sub = cycles spent in phase.
   int          m_ph [2];
   int          m_sub[2];
   bit          m_pend[2], m_stp[2], m_arm[2];
   logic [15:0] m_cnt[2];
   bit          m_valid = 1'b0;

   function automatic int div_of(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [3:0] m_en(int i);
      if (m_ph[i] < 0 || m_sub[i] != div_of(i) - 1 || (m_ph[i] == 2 && wt)) return 4'b0000;
      return 4'b1000 >> m_ph[i];
   endfunction

   function automatic logic [3:0] dut_en(int i);
      return (i == 0) ? {ft1, dc1, ex1, wb1} : {ft4, dc4, ex4, wb4};
   endfunction

   function automatic logic [21:0] dut_obs(int i);
      return (i == 0) ? {ft1, dc1, ex1, wb1, hl1, rn1, cnt1} : {ft4, dc4, ex4, wb4, hl4, rn4, cnt4};
   endfunction

   task automatic model_check();
      if (m_valid) begin
         for (int i = 0; i < 2; i++)
            chk((i == 0) ? "model_div1" : "model_div4", dut_obs(i),
                {m_en(i), (m_ph[i] < 0), (m_ph[i] >= 0), m_cnt[i]});
      end
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_ph[i] = -1; m_sub[i] = 0; m_pend[i] = 1'b0; m_stp[i] = 1'b0;
            m_arm[i] = 1'b1; m_cnt[i] = 16'd0;
         end
         m_valid = 1'b1;
      end else if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] e;
            bit to_halt;
            bit ex_fire;
            e = m_en(i);
            ex_fire = e[1];
            to_halt = 1'b0;
            if (m_ph[i] < 0) begin
               if (step) begin
                  m_ph[i] = 0; m_stp[i] = 1'b1;
               end else if (run && !m_pend[i] && m_arm[i]) begin
                  m_ph[i] = 0;
               end
            end else if (e != 4'b0000) begin
               if (m_ph[i] == 3) begin
                  m_cnt[i] = m_cnt[i] + 16'd1;
                  to_halt = m_pend[i] || hreq || m_stp[i] || !run;
               end
               m_ph[i] = to_halt ? -1 : (m_ph[i] + 1) % 4;
               m_sub[i] = 0;
            end else if (m_sub[i] < div_of(i) - 1) begin
               m_sub[i] = m_sub[i] + 1;
            end
            if (to_halt) begin
               m_pend[i] = 1'b0; m_stp[i] = 1'b0;
            end else if (hreq || (ex_fire && op == OP_HLT)) begin
               m_pend[i] = 1'b1;
            end
            if (!run) m_arm[i] = 1'b1;
            else if (to_halt) m_arm[i] = 1'b0;
         end
      end
   endtask

   task automatic half_check();
      @(negedge clk);
      model_check();
   endtask

   task automatic half_adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      half_check();
      half_adv();
   endtask

   typedef struct {
      bit          chk;
      bit          rst;
      bit          run;
      bit          wt;
      logic [3:0]  op;
      logic [3:0]  en;
      bit          halted;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(bit c, bit r, bit rn, bit w, logic [3:0] o, logic [3:0] e, bit h, logic [15:0] n);
      vec_t v;
      v.chk = c; v.rst = r; v.run = rn; v.wt = w; v.op = o; v.en = e; v.halted = h; v.cnt = n;
      tbl.push_back(v);
   endtask

   // Single-step from HALTED on the DIV=1 instance, optionally with HALT_REQ in the same cycle.
   task automatic do_step(bit with_hreq);
      logic [15:0] base;
      int extra;
      base = m_cnt[0];
      step = 1'b1; hreq = with_hreq;
      half_check();
      chk("step_start_halted", hl1, 1'b1);
      half_adv();
      step = 1'b0; hreq = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [3:0] pat;
         pat = 4'b1000 >> k;
         half_check();
         chk("step_phase_en", {ft1, dc1, ex1, wb1}, pat);
         half_adv();
      end
      half_check();
      chk("step_end_halted", hl1, 1'b1);
      chk("step_cnt", cnt1, base + 16'd1);
      half_adv();
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         half_check();
         if ({ft1, dc1, ex1, wb1} != 4'b0000) extra++;
         half_adv();
      end
      chk("step_no_extra_en", extra, 0);
   endtask

   initial begin
      int nft;
      int n;
      int mh;
      int q[4][$];
      logic [3:0] e4;

      // DIV=1 free run, EX wait-state stall of 5 cycles, then HLT opcode.
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 16'd0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, 16'd0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b1, 16'd0);
      for (int k = 0; k < 3; k++)
         for (int p = 0; p < 4; p++)
            add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1000 >> p, 1'b0, 16'(k));
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 1'b0, 16'd3);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0100, 1'b0, 16'd3);
      for (int k = 0; k < 5; k++)
         add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 16'd3);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0010, 1'b0, 16'd3);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0001, 1'b0, 16'd3);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1000, 1'b0, 16'd4);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0100, 1'b0, 16'd4);
      add(1'b1, 1'b0, 1'b1, 1'b0, OP_HLT, 4'b0010, 1'b0, 16'd4);
      add(1'b1, 1'b0, 1'b1, 1'b0, OP_HLT, 4'b0001, 1'b0, 16'd4);
      add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b1, 16'd5);

      foreach (tbl[r]) begin
         rst = tbl[r].rst; run = tbl[r].run; wt = tbl[r].wt; op = tbl[r].op;
         half_check();
         if (tbl[r].chk) begin
            chk("tbl_en", {ft1, dc1, ex1, wb1}, tbl[r].en);
            chk("tbl_halted", hl1, tbl[r].halted);
            chk("tbl_cnt", cnt1, tbl[r].cnt);
         end
         half_adv();
      end

      // HLT retired with RUN still high: no restart.
      nft = 0;
      for (int k = 0; k < 50; k++) begin
         half_check();
         if (ft1) nft++;
         half_adv();
      end
      chk("hlt_no_restart", nft, 0);
      chk("hlt_still_halted", hl1, 1'b1);

      // RUN re-armed, stall in EX, reset mid-stall, then resume at FT.
      run = 1'b0; tick();
      run = 1'b1; wt = 1'b1;
      half_check(); chk("rearm_halted", hl1, 1'b1); half_adv();
      half_check(); chk("rearm_ft", ft1, 1'b1); half_adv();
      half_check(); chk("rearm_dc", dc1, 1'b1); half_adv();
      half_check(); chk("stall_no_ex", ex1, 1'b0); half_adv();
      tick();
      rst = 1'b1;
      half_check(); chk("stall_rst_no_ex", ex1, 1'b0); half_adv();
      rst = 1'b0;
      half_check();
      chk("rst_en_zero", {ft1, dc1, ex1, wb1}, 4'b0000);
      chk("rst_halted", hl1, 1'b1);
      chk("rst_cnt", cnt1, 16'd0);
      half_adv();
      wt = 1'b0;
      half_check(); chk("rst_resume_ft", ft1, 1'b1); half_adv();

      // Drop RUN: current instruction completes, then single steps.
      run = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!hl1 && n < 20);
      chk("run_drop_halts", hl1, 1'b1);
      for (int k = 0; k < 8; k++) tick();
      do_step(1'b0);
      do_step(1'b1);

      // DIV=4 spacing after a fresh reset.
      rst = 1'b1; tick();
      rst = 1'b0; run = 1'b1;
      mh = 0;
      for (int c = 0; c < 80; c++) begin
         half_check();
         e4 = {ft4, dc4, ex4, wb4};
         if ($countones(e4) > 1) mh++;
         for (int p = 0; p < 4; p++)
            if (e4[3-p]) q[p].push_back(c);
         half_adv();
      end
      chk("d4_ft_count", q[0].size(), 5);
      chk("d4_ft_period", q[0][1] - q[0][0], 16);
      chk("d4_wb_period", q[3][1] - q[3][0], 16);
      chk("d4_dc_after_ft", q[1][0] - q[0][0], 4);
      chk("d4_ex_after_dc", q[2][0] - q[1][0], 4);
      chk("d4_wb_after_ex", q[3][0] - q[2][0], 4);
      chk("d4_one_hot", mh, 0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0) run = ~run;
         step = ($urandom_range(0, 15) == 0);
         hreq = ($urandom_range(0, 29) == 0);
         op = ($urandom_range(0, 9) == 0) ? OP_HLT : 4'($urandom_range(0, 14));
         wt = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
